// File: rtl/csr_ctrl_pkg.sv
// +--------------------------------------------------------------------------+
// | csr_ctrl_pkg : shared funct3 codes, FSM state type and CSR addresses      |
// | Revision     : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

package csr_ctrl_pkg;

  localparam logic [2:0] CSRRW  = 3'b001;
  localparam logic [2:0] CSRRS  = 3'b010;
  localparam logic [2:0] CSRRC  = 3'b011;
  localparam logic [2:0] CSRRWI = 3'b101;
  localparam logic [2:0] CSRRSI = 3'b110;
  localparam logic [2:0] CSRRCI = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_READ  = 2'd1,
    ST_WRITE = 2'd2,
    ST_RESP  = 2'd3
  } state_e;

  localparam logic [11:0] CSR_CYCLE    = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH   = 12'hC80;
  localparam logic [11:0] CSR_INSTRET  = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH = 12'hC82;
  localparam logic [11:0] CSR_MSCRATCH = 12'h340;

  // funct3 x00 encodings are not CSR instructions.
  function automatic logic is_csr_op(input logic [2:0] funct3);
    return funct3[1:0] != 2'b00;
  endfunction

endpackage

`default_nettype wire

// File: rtl/csr_op_unit.sv
// +--------------------------------------------------------------------------+
// | csr_op_unit : combinational CSR new-value and write-request computation  |
// | Revision    : 1.0                                                        |
// +--------------------------------------------------------------------------+
`default_nettype none

module csr_op_unit
  import csr_ctrl_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [2:0]      funct3_i,
  input  logic [XLEN-1:0] old_i,
  input  logic [XLEN-1:0] operand_i,
  input  logic            rs1_is_zero_i,
  output logic [XLEN-1:0] new_o,
  output logic            write_req_o
);

  logic src_zero;

  // Set/clear forms only write when their source is non-zero (rs1!=x0 or zimm!=0).
  assign src_zero = funct3_i[2] ? (operand_i == '0) : rs1_is_zero_i;

  always_comb begin
    new_o       = old_i;
    write_req_o = 1'b0;
    case (funct3_i)
      CSRRW, CSRRWI: begin
        new_o       = operand_i;
        write_req_o = 1'b1;
      end
      CSRRS, CSRRSI: begin
        new_o       = old_i | operand_i;
        write_req_o = !src_zero;
      end
      CSRRC, CSRRCI: begin
        new_o       = old_i & ~operand_i;
        write_req_o = !src_zero;
      end
      default: ;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/csr_rmw_ctrl.sv
// +--------------------------------------------------------------------------+
// | csr_rmw_ctrl : sequences CSR instructions as read/modify/write accesses  |
// | Option: CSR_RO_PASS_EN drops read-only writes silently. Revision : 1.0   |
// +--------------------------------------------------------------------------+
`default_nettype none

module csr_rmw_ctrl
  import csr_ctrl_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int CSR_ADDR_W = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid_i,
  output logic                  req_ready_o,
  input  logic [2:0]            req_funct3_i,
  input  logic [CSR_ADDR_W-1:0] req_addr_i,
  input  logic [XLEN-1:0]       req_rs1_data_i,
  input  logic [4:0]            req_zimm_i,
  input  logic                  req_rs1_is_zero_i,
  output logic                  rsp_valid_o,
  input  logic                  rsp_ready_i,
  output logic [XLEN-1:0]       rsp_rdata_o,
  output logic                  rsp_illegal_o,
  output logic [CSR_ADDR_W-1:0] csr_rd_addr_o,
  input  logic [XLEN-1:0]       csr_rd_data_i,
  input  logic                  csr_rd_hit_i,
  output logic                  csr_we_o,
  output logic [CSR_ADDR_W-1:0] csr_wr_addr_o,
  output logic [XLEN-1:0]       csr_wr_data_o,
  output logic                  csr_stall_o
);

  state_e                state_q;
  logic                  req_ready_q;
  logic                  rsp_valid_q;
  logic                  rsp_illegal_q;
  logic                  csr_we_q;
  logic                  hit_q;
  logic                  rs1_zero_q;
  logic [2:0]            funct3_q;
  logic [CSR_ADDR_W-1:0] addr_q;
  logic [CSR_ADDR_W-1:0] wr_addr_q;
  logic [XLEN-1:0]       operand_q;
  logic [XLEN-1:0]       old_q;
  logic [XLEN-1:0]       rsp_rdata_q;
  logic [XLEN-1:0]       wr_data_q;

  logic [XLEN-1:0]       operand_d;
  logic [XLEN-1:0]       new_val_d;
  logic                  write_req_d;
  logic                  ro_addr_d;
  logic                  illegal_d;
  logic                  do_write_d;

  assign operand_d = req_funct3_i[2] ? {{(XLEN-5){1'b0}}, req_zimm_i} : req_rs1_data_i;
  assign ro_addr_d = (addr_q[CSR_ADDR_W-1 -: 2] == 2'b11);

  // Read data is combinational, so the modify step works directly on it in READ.
  csr_op_unit #(
    .XLEN(XLEN)
  ) u_op (
    .funct3_i     (funct3_q),
    .old_i        (csr_rd_data_i),
    .operand_i    (operand_q),
    .rs1_is_zero_i(rs1_zero_q),
    .new_o        (new_val_d),
    .write_req_o  (write_req_d)
  );

`ifdef CSR_RO_PASS_EN
  assign illegal_d  = !csr_rd_hit_i;
  assign do_write_d = write_req_d && !ro_addr_d && !illegal_d;
`else
  assign illegal_d  = !csr_rd_hit_i || (write_req_d && ro_addr_d);
  assign do_write_d = write_req_d && !illegal_d;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      req_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_illegal_q <= 1'b0;
      rsp_rdata_q   <= '0;
      csr_we_q      <= 1'b0;
      hit_q         <= 1'b0;
      rs1_zero_q    <= 1'b0;
      funct3_q      <= 3'b000;
      addr_q        <= '0;
      wr_addr_q     <= '0;
      wr_data_q     <= '0;
      operand_q     <= '0;
      old_q         <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (req_valid_i) begin
            funct3_q    <= req_funct3_i;
            addr_q      <= req_addr_i;
            operand_q   <= operand_d;
            rs1_zero_q  <= req_rs1_is_zero_i;
            req_ready_q <= 1'b0;
            if (is_csr_op(req_funct3_i)) begin
              state_q <= ST_READ;
            end else begin
              state_q       <= ST_RESP;
              rsp_valid_q   <= 1'b1;
              rsp_illegal_q <= 1'b1;
              rsp_rdata_q   <= '0;
            end
          end
        end
        ST_READ: begin
          old_q <= csr_rd_data_i;
          hit_q <= csr_rd_hit_i;
          if (do_write_d) begin
            state_q   <= ST_WRITE;
            csr_we_q  <= 1'b1;
            wr_addr_q <= addr_q;
            wr_data_q <= new_val_d;
          end else begin
            state_q       <= ST_RESP;
            rsp_valid_q   <= 1'b1;
            rsp_illegal_q <= illegal_d;
            rsp_rdata_q   <= illegal_d ? '0 : csr_rd_data_i;
          end
        end
        ST_WRITE: begin
          state_q       <= ST_RESP;
          csr_we_q      <= 1'b0;
          rsp_valid_q   <= 1'b1;
          rsp_illegal_q <= !hit_q;
          rsp_rdata_q   <= hit_q ? old_q : '0;
        end
        ST_RESP: begin
          if (rsp_ready_i) begin
            state_q     <= ST_IDLE;
            rsp_valid_q <= 1'b0;
            req_ready_q <= 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign req_ready_o   = req_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_illegal_o = rsp_illegal_q;
  assign csr_rd_addr_o = addr_q;
  assign csr_we_o      = csr_we_q;
  assign csr_wr_addr_o = wr_addr_q;
  assign csr_wr_data_o = wr_data_q;
  assign csr_stall_o   = (state_q != ST_IDLE) || (req_valid_i && (state_q == ST_IDLE));

endmodule

`default_nettype wire

// File: tb/tb_csr_rmw_ctrl.sv
// +--------------------------------------------------------------------------+
// | tb_csr_rmw_ctrl : scoreboard bench for csr_rmw_ctrl with a CSR model     |
// | Revision        : 1.0                                                    |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_csr_rmw_ctrl;
  import csr_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [2:0]  req_funct3 = 3'b000;
  logic [11:0] req_addr = '0;
  logic [31:0] req_rs1_data = '0;
  logic [4:0]  req_zimm = '0;
  logic        req_rs1_is_zero = 1'b0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_illegal;
  logic [11:0] csr_rd_addr;
  logic [31:0] csr_rd_data;
  logic        csr_rd_hit;
  logic        csr_we;
  logic [11:0] csr_wr_addr;
  logic [31:0] csr_wr_data;
  logic        csr_stall;

  always #5 clk = ~clk;

  csr_rmw_ctrl #(.XLEN(32), .CSR_ADDR_W(12)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_i      (req_valid),
    .req_ready_o      (req_ready),
    .req_funct3_i     (req_funct3),
    .req_addr_i       (req_addr),
    .req_rs1_data_i   (req_rs1_data),
    .req_zimm_i       (req_zimm),
    .req_rs1_is_zero_i(req_rs1_is_zero),
    .rsp_valid_o      (rsp_valid),
    .rsp_ready_i      (rsp_ready),
    .rsp_rdata_o      (rsp_rdata),
    .rsp_illegal_o    (rsp_illegal),
    .csr_rd_addr_o    (csr_rd_addr),
    .csr_rd_data_i    (csr_rd_data),
    .csr_rd_hit_i     (csr_rd_hit),
    .csr_we_o         (csr_we),
    .csr_wr_addr_o    (csr_wr_addr),
    .csr_wr_data_o    (csr_wr_data),
    .csr_stall_o      (csr_stall)
  );

  // CSR storage model: only the listed addresses are implemented.
  logic [31:0] mem [0:4095];

  function automatic logic implemented(input logic [11:0] a);
    return (a == CSR_CYCLE) || (a == CSR_CYCLEH) || (a == CSR_INSTRET) ||
           (a == CSR_INSTRETH) || (a == CSR_MSCRATCH);
  endfunction

  assign csr_rd_data = mem[csr_rd_addr];
  assign csr_rd_hit  = implemented(csr_rd_addr);

  always @(posedge clk) if (csr_we) mem[csr_wr_addr] = csr_wr_data;

  typedef struct {
    string       name;
    logic [31:0] rdata;
    logic        ill;
    int          nwe;
    logic [31:0] wdata;
    int          lat;
  } exp_t;

  exp_t sb[$];
  exp_t m_e;
  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;

  int          acc_cyc = 0;
  int          we_cnt = 0;
  int          we_cyc = 0;
  int          lat = 0;
  bit          seen = 1'b0;
  logic [31:0] we_data = '0;
  logic [31:0] held_rdata = '0;
  logic        held_ill = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: tracks accept/write timing and scores each response handshake.
  always @(negedge clk) begin
    if (!rst) begin
      if (req_valid && req_ready) begin
        acc_cyc = cyc;
        we_cnt  = 0;
        seen    = 1'b0;
      end
      if (csr_we) begin
        we_cnt++;
        we_data = csr_wr_data;
        we_cyc  = cyc - acc_cyc;
      end
      if (rsp_valid) begin
        if (!seen) begin
          seen       = 1'b1;
          lat        = cyc - acc_cyc;
          held_rdata = rsp_rdata;
          held_ill   = rsp_illegal;
        end else begin
          chk("rsp_rdata stable", rsp_rdata, held_rdata);
          chk("rsp_illegal stable", {31'd0, rsp_illegal}, {31'd0, held_ill});
        end
        chk("req_ready low in RESP", {31'd0, req_ready}, 32'd0);
        if (rsp_ready) begin
          if (sb.size() == 0) begin
            n_chk++;
            n_fail++;
            $display("FAIL unexpected response: rdata 0x%08h", rsp_rdata);
          end else begin
            m_e = sb.pop_front();
            chk({m_e.name, " rdata"}, rsp_rdata, m_e.rdata);
            chk({m_e.name, " illegal"}, {31'd0, rsp_illegal}, {31'd0, m_e.ill});
            chk({m_e.name, " latency"}, lat, m_e.lat);
            chk({m_e.name, " we count"}, we_cnt, m_e.nwe);
            if (m_e.nwe != 0) begin
              chk({m_e.name, " wdata"}, we_data, m_e.wdata);
              chk({m_e.name, " we cycle"}, we_cyc, 2);
            end
          end
          seen = 1'b0;
        end
      end
    end
  end

  task automatic issue(input string name, input logic [2:0] f3, input logic [11:0] a,
                       input logic [31:0] rs1, input logic [4:0] z, input logic rz,
                       input logic [31:0] er, input logic ei, input int nwe,
                       input logic [31:0] ewd, input int elat, input bit push = 1'b1);
    bit ok = 1'b0;
    exp_t e;
    if (push) begin
      e.name = name; e.rdata = er; e.ill = ei; e.nwe = nwe; e.wdata = ewd; e.lat = elat;
      sb.push_back(e);
    end
    @(posedge clk); #1;
    req_funct3 = f3; req_addr = a; req_rs1_data = rs1; req_zimm = z; req_rs1_is_zero = rz;
    req_valid  = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      @(negedge clk);
      if (req_ready) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL %s accept timeout: req_ready 0 expected 1", name);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 1'b0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      if (sb.size() == 0) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL drain timeout: %0d responses pending, expected 0", sb.size());
    end
    @(negedge clk);
  endtask

  logic [31:0] ro_rdata_c02;
  logic        ro_ill;
  logic [31:0] ro_rdata_c00;

  initial begin
    bit ok;
`ifdef CSR_RO_PASS_EN
    ro_ill = 1'b0; ro_rdata_c02 = 32'h55; ro_rdata_c00 = 32'h1234;
`else
    ro_ill = 1'b1; ro_rdata_c02 = 32'h0;  ro_rdata_c00 = 32'h0;
`endif
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    mem[12'hC00] = 32'h1234;
    mem[12'hC02] = 32'h55;
    mem[12'h7FF] = 32'hBAD;

    #1 rst = 1'b1;
    #1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset csr_we", {31'd0, csr_we}, 32'd0);
    chk("reset csr_stall", {31'd0, csr_stall}, 32'd0);
    chk("reset rsp_rdata", rsp_rdata, 32'd0);
    chk("reset wr_data", csr_wr_data, 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    issue("rw_mscratch", CSRRW, CSR_MSCRATCH, 32'hDEADBEEF, 5'd0, 1'b0, 32'h0, 1'b0, 1, 32'hDEADBEEF, 3);
    issue("rs_cycle_x0", CSRRS, CSR_CYCLE, 32'h0000FFFF, 5'd0, 1'b1, 32'h1234, 1'b0, 0, 32'h0, 2);
    issue("rwi_instret", CSRRWI, CSR_INSTRET, 32'h0, 5'd5, 1'b0, ro_rdata_c02, ro_ill, 0, 32'h0, 2);
    drain();
    mem[CSR_MSCRATCH] = 32'hFF;
    issue("rc_mscratch", CSRRC, CSR_MSCRATCH, 32'h0F, 5'd0, 1'b0, 32'hFF, 1'b0, 1, 32'hF0, 3);
    issue("unimpl_7ff", CSRRW, 12'h7FF, 32'h1, 5'd0, 1'b0, 32'h0, 1'b1, 0, 32'h0, 2);
    issue("funct3_100", 3'b100, CSR_MSCRATCH, 32'h1, 5'd0, 1'b0, 32'h0, 1'b1, 0, 32'h0, 1);
    issue("rs_mscratch", CSRRS, CSR_MSCRATCH, 32'h0F00, 5'd0, 1'b0, 32'hF0, 1'b0, 1, 32'hFF0, 3);
    issue("rsi_zero", CSRRSI, CSR_MSCRATCH, 32'h0, 5'd0, 1'b0, 32'hFF0, 1'b0, 0, 32'h0, 2);
    issue("rci_mscratch", CSRRCI, CSR_MSCRATCH, 32'h0, 5'h10, 1'b0, 32'hFF0, 1'b0, 1, 32'hFE0, 3);
    issue("rs_cycle_ro", CSRRS, CSR_CYCLE, 32'h1, 5'd0, 1'b0, ro_rdata_c00, ro_ill, 0, 32'h0, 2);
    drain();

    // Response back-pressure: hold rsp_ready low for five cycles of rsp_valid.
    rsp_ready = 1'b0;
    issue("rw_hold", CSRRW, CSR_MSCRATCH, 32'h12345678, 5'd0, 1'b0, 32'hFE0, 1'b0, 1, 32'h12345678, 3);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (rsp_valid) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL rw_hold rsp_valid timeout: rsp_valid 0 expected 1");
    end
    repeat (5) @(negedge clk);
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    drain();

    // Reset during WRITE: the strobe must vanish and the write must be lost.
    issue("rw_reset", CSRRW, CSR_MSCRATCH, 32'hAAAA5555, 5'd0, 1'b0, 32'h0, 1'b0, 0, 32'h0, 0, 1'b0);
    ok = 1'b0;
    for (int i = 0; i < 10 && !ok; i++) begin
      @(negedge clk);
      if (csr_we) ok = 1'b1;
    end
    if (!ok) begin
      n_chk++; n_fail++;
      $display("FAIL rw_reset csr_we timeout: csr_we 0 expected 1");
    end
    #2 rst = 1'b1;
    #1;
    chk("mid-reset csr_we", {31'd0, csr_we}, 32'd0);
    chk("mid-reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("mid-reset csr_stall", {31'd0, csr_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid-reset write lost", mem[CSR_MSCRATCH], 32'h12345678);
    issue("rw_after_reset", CSRRW, CSR_MSCRATCH, 32'h0, 5'd0, 1'b0, 32'h12345678, 1'b0, 1, 32'h0, 3);
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout: simulation time exceeded limit");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/csr_rmw_ctrl.md
Name: csr_rmw_ctrl

Overview:
- Sequences CSR instructions (CSRRW/RS/RC and the immediate forms) from the EXE stage into the CSR storage block as explicit read, then modify, then write transactions.
- Sits between EXE and the CSR register/counter block.
- Holds the pipeline with a stall output while an access is in flight.
- Flags illegal accesses: writes to read-only CSRs and accesses to unimplemented CSRs.

Parameters:
- XLEN, 32, data width of CSR read/write paths.
- CSR_ADDR_W, 12, CSR address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  EXE presents a CSR instruction
- req_ready  out  1  controller accepts request this cycle
- req_funct3  in  3  instruction funct3 (001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI)
- req_addr  in  CSR_ADDR_W  CSR address (imm[11:0])
- req_rs1_data  in  XLEN  rs1 value, used when funct3[2]=0
- req_zimm  in  5  uimm, zero-extended, used when funct3[2]=1
- req_rs1_is_zero  in  1  rs1 index is x0 (register forms only)
- rsp_valid  out  1  result available
- rsp_ready  in  1  WB consumes result
- rsp_rdata  out  XLEN  old CSR value for rd
- rsp_illegal  out  1  access illegal; rsp_rdata = 0
- csr_rd_addr  out  CSR_ADDR_W  read address to CSR block
- csr_rd_data  in  XLEN  combinational read data
- csr_rd_hit  in  1  address implemented
- csr_we  out  1  one-cycle write strobe
- csr_wr_addr  out  CSR_ADDR_W  write address
- csr_wr_data  out  XLEN  write data
- csr_stall  out  1  pipeline hold

Behaviour:
- FSM states: IDLE, READ, WRITE, RESP. Reset state is IDLE.
- Reset values: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_illegal=0, csr_we=0, csr_stall=0, all address/data outputs 0.
- IDLE:
  - req_ready=1.
  - On req_valid, latch funct3, addr and operand (zimm zero-extended to XLEN when funct3[2]=1), then go to READ.
  - funct3 000 or 100 is not a CSR op: accept the request and go directly to RESP with rsp_illegal=1.
- READ:
  - Drive csr_rd_addr; capture csr_rd_data into old_q and csr_rd_hit into hit_q.
  - Compute new value:
    - RW: operand.
    - RS: old | operand.
    - RC: old & ~operand.
  - write_req = RW/RWI always; RS/RC only when rs1 is not x0; RSI/RCI only when zimm != 0.
  - illegal = !hit_q, or (write_req and addr[11:10]==2'b11).
  - If write_req and not illegal, go to WRITE; otherwise go to RESP.
- WRITE:
  - csr_we=1 for exactly one cycle, with csr_wr_addr and csr_wr_data stable.
  - Then go to RESP.
- RESP:
  - rsp_valid=1; rsp_rdata = old_q, or 0 if illegal.
  - Hold outputs until rsp_ready=1, then go to IDLE. rsp_valid deasserts the next cycle.
- Latency: accepted at cycle 0 → READ at cycle 1 → WRITE at cycle 2 → rsp_valid at cycle 3. A non-writing op reaches RESP at cycle 2.
- csr_stall = (state != IDLE) || (req_valid && state == IDLE).
- req_ready = 0 outside IDLE. No new request is accepted in the same cycle as a response handshake; back-to-back throughput is at least 1 op per 4 cycles.
- Reset asserted mid-operation: immediately return to IDLE and clear csr_we; the pending write is lost.
- rsp_ready held high in advance: RESP still lasts at least one cycle.

Optional Feature:
- CSR_RO_PASS_EN.
- Defined: writes to read-only addresses (addr[11:10]==2'b11) are silently dropped instead of raising illegal. rsp_illegal=0, rsp_rdata=old value, no WRITE state.
- Undefined: behaviour exactly as above (illegal raised).

Decomposition:
- Package csr_ctrl_pkg:
  - funct3 localparams (CSRRW…CSRRCI).
  - FSM state enum.
  - CSR address constants: CYCLE 0xC00, CYCLEH 0xC80, INSTRET 0xC02, INSTRETH 0xC82, MSCRATCH 0x340.
- Sub-module csr_op_unit: combinational new-value and write_req computation from funct3, old value, operand and zero flags.

Test Plan:
- CSRRW to 0x340 with rs1_data=0xDEADBEEF, prior 0x0 → rsp_rdata=0x0 at cycle 3; csr_we pulse at cycle 2 with wr_data 0xDEADBEEF.
- CSRRS to 0xC00 with rs1=x0, csr_rd_data=0x1234 → no csr_we; rsp_valid at cycle 2, rsp_rdata=0x1234, illegal=0.
- CSRRWI to 0xC02 with zimm=5 → rsp_illegal=1, rsp_rdata=0, no csr_we. With CSR_RO_PASS_EN → illegal=0, rdata=old.
- CSRRC to 0x340 with old=0xFF, rs1_data=0x0F → wr_data=0xF0; rsp_rdata=0xFF.
- Access to 0x7FF with csr_rd_hit=0 → rsp_illegal=1. funct3=100 → illegal at RESP, no READ.
- rsp_ready held low for 5 cycles → rsp_valid/rdata stable and req_ready=0 throughout. rst pulse during WRITE → csr_we drops immediately, state IDLE, req_ready=1.
